ir_seqdiv: RTL and testbench
============================

IR_SEQDIV -- requirements
Module: ir_seqdiv

Interface
REQ-001 SHALL have parameter N, default 8, giving the operand, quotient and remainder width (N >= 2).
REQ-002 SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESETN, input, 1 bit, the reset: synchronous and active-low.
REQ-004 SHALL have port START, input, 1 bit, requests a division of A by B.
REQ-005 SHALL have port A, input, N bits, the dividend, sampled only on an accepted START.
REQ-006 SHALL have port B, input, N bits, the divisor, sampled only on an accepted START.
REQ-007 SHALL have port BUSY, output, 1 bit, high while an operation is in flight.
REQ-008 SHALL have port DONE, output, 1 bit, a one-cycle pulse marking valid results.
REQ-009 SHALL have port Q, output, N bits, the quotient.
REQ-010 SHALL have port R, output, N bits, the remainder.
REQ-011 SHALL have port DIVZ, output, 1 bit, set when the divisor was zero.

Function
REQ-012 SHALL implement a restoring shift-subtract divider with three states:
  - IDLE -> RUN on START=1.
  - RUN -> DONE after exactly N step cycles.
  - DONE -> IDLE unconditionally.
REQ-013 SHALL accept START only in IDLE (BUSY=0); START in RUN or DONE SHALL be ignored with no effect on the in-flight result.
REQ-014 SHALL drive BUSY=1 in RUN and DONE, and DONE=1 only in DONE.
REQ-015 SHALL give fixed latency: START accepted in cycle t gives DONE=1 in cycle t+N+1 and BUSY=0 again in cycle t+N+2; latency SHALL NOT depend on operand values.
REQ-016 SHALL perform each RUN step as follows:
  - Shift the partial remainder left by one, bringing in the next dividend MSB.
  - Subtract the zero-extended divisor at N+1 bits.
  - A non-negative difference is kept, with quotient bit 1.
  - Otherwise the partial remainder is restored, with quotient bit 0.
REQ-017 Unsigned result SHALL satisfy A = Q*B + R with R < B for B != 0.
REQ-018 For B=0, the bench-visible result SHALL be Q = all ones, R = A, DIVZ=1, at the same latency as REQ-015; DIVZ SHALL be 0 for any B != 0.
REQ-019 Q, R and DIVZ SHALL update only on the DONE transition and SHALL hold their values through IDLE until the next DONE.

Reset
REQ-020 With RESETN=0 at a rising edge: state=IDLE; BUSY=0; DONE=0; Q, R and DIVZ all 0; any in-flight operation is discarded without a DONE pulse.
REQ-021 START SHALL be ignored during the cycle RESETN=0 is sampled; the first acceptable START is in the cycle after RESETN returns to 1.

Configuration
REQ-022 Macro IR_SEQDIV_SIGNED_EN, when defined, SHALL add input port SIGNED (1 bit), sampled with START; when undefined the block is unsigned-only and has no SIGNED port.
REQ-023 With the macro defined and SIGNED=1, the operation SHALL be signed division:
  - A and B are two's complement.
  - Magnitudes are divided by the unsigned core.
  - Q is negated when the operand signs differ (truncation toward zero).
  - R takes the sign of A.
  - Latency is unchanged (REQ-015).
REQ-024 Signed boundary cases SHALL give:
  - -2^(N-1) / -1 -> Q = -2^(N-1) (wrapped), R = 0.
  - B = 0 -> Q = all ones, R = A, DIVZ = 1.

Structure
REQ-025 Shared package ir_arith_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the default width constant.
REQ-026 One sub-module ir_div_step SHALL implement a single combinational restoring step (N+1-bit subtract, borrow-driven select), instantiated once and reused each RUN cycle.

Verification
REQ-027 N=8, unsigned, A=100, B=7, START at t -> DONE at t+9 with Q=14, R=2, DIVZ=0.
REQ-028 A=5, B=0 -> DONE at t+9 with Q=0xFF, R=5, DIVZ=1; then A=255, B=1 -> Q=255, R=0, DIVZ=0.
REQ-029 START pulsed again at t+3 with A=9, B=3 while running 100/7 -> result still Q=14, R=2; no second DONE pulse.
REQ-030 RESETN=0 at t+4 during an operation -> BUSY=0, DONE never pulses, Q=R=0; a new START at t+6 completes normally at t+15.
REQ-031 IR_SEQDIV_SIGNED_EN defined, SIGNED=1:
  - A=0xF9 (-7), B=2 -> Q=0xFD (-3), R=0xFF (-1).
  - A=0x80, B=0xFF -> Q=0x80, R=0.

Source files
------------

// File: rtl/ir_arith_pkg.sv
// Shared arithmetic definitions: divider FSM states and the default operand width.
package ir_arith_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ir_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor,
// keep the difference on no borrow, otherwise restore the shifted remainder.
module ir_div_step #(
   parameter int N = 8
) (
   input  logic [N-1:0] part_rem,
   input  logic         next_bit,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] new_rem,
   output logic         qbit
);

   logic [N:0] shifted;
   logic [N:0] diff;
   logic       borrow;

   assign shifted        = {part_rem, next_bit};
   assign {borrow, diff} = {1'b0, shifted} - {2'b00, divisor};
   assign qbit           = ~borrow;
   // Whenever the divisor is nonzero the kept value is below it, so N bits always suffice.
   assign new_rem        = N'(qbit ? diff : shifted);

endmodule

// File: rtl/ir_seqdiv.sv
// Sequential restoring divider: START in IDLE gives DONE N+1 cycles later; START is ignored while BUSY.
// Optional signed mode (truncating, remainder takes dividend sign) when IR_SEQDIV_SIGNED_EN is defined.
module ir_seqdiv #(
   parameter int N = ir_arith_pkg::DEF_WIDTH
) (
   input  logic         CLK,
   input  logic         RESETN,
   input  logic         START,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
`ifdef IR_SEQDIV_SIGNED_EN
   input  logic         SIGNED,
`endif
   output logic         BUSY,
   output logic         DONE,
   output logic [N-1:0] Q,
   output logic [N-1:0] R,
   output logic         DIVZ
);

   localparam int CW = $clog2(N + 1);

   ir_arith_pkg::state_t state, state_nxt;

   logic [CW-1:0] cnt;
   logic [N-1:0]  dvd;
   logic [N-1:0]  dvs;
   logic [N-1:0]  rem;
   logic [N-1:0]  a_hold;
   logic          neg_q;
   logic          neg_r;
   logic          divz_pend;
   logic          sgn;
   logic          last_step;
   logic [N-1:0]  a_mag;
   logic [N-1:0]  b_mag;
   logic [N-1:0]  step_rem;
   logic          step_q;
   logic [N-1:0]  q_raw;
   logic [N-1:0]  q_fin;
   logic [N-1:0]  r_fin;

`ifdef IR_SEQDIV_SIGNED_EN
   assign sgn = SIGNED;
`else
   assign sgn = 1'b0;
`endif

   assign a_mag     = (sgn && A[N-1]) ? (~A + 1'b1) : A;
   assign b_mag     = (sgn && B[N-1]) ? (~B + 1'b1) : B;
   assign last_step = (cnt == CW'(N - 1));
   assign q_raw     = {dvd[N-2:0], step_q};

   // Divide-by-zero result is forced so it is independent of the sign fixups.
   assign q_fin = divz_pend ? '1     : (neg_q ? (~q_raw + 1'b1)    : q_raw);
   assign r_fin = divz_pend ? a_hold : (neg_r ? (~step_rem + 1'b1) : step_rem);

   ir_div_step #(.N(N)) u_step (
      .part_rem (rem),
      .next_bit (dvd[N-1]),
      .divisor  (dvs),
      .new_rem  (step_rem),
      .qbit     (step_q)
   );

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state <= ir_arith_pkg::IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      BUSY      = 1'b1;
      DONE      = 1'b0;
      case (state)
         ir_arith_pkg::IDLE: begin
            BUSY = 1'b0;
            if (START) state_nxt = ir_arith_pkg::RUN;
         end
         ir_arith_pkg::RUN: begin
            if (last_step) state_nxt = ir_arith_pkg::DONE;
         end
         ir_arith_pkg::DONE: begin
            DONE      = 1'b1;
            state_nxt = ir_arith_pkg::IDLE;
         end
         default: begin
            BUSY      = 1'b0;
            state_nxt = ir_arith_pkg::IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         cnt       <= '0;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         a_hold    <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         divz_pend <= 1'b0;
         Q         <= '0;
         R         <= '0;
         DIVZ      <= 1'b0;
      end else begin
         case (state)
            ir_arith_pkg::IDLE: begin
               if (START) begin
                  dvd       <= a_mag;
                  dvs       <= b_mag;
                  rem       <= '0;
                  cnt       <= '0;
                  a_hold    <= A;
                  neg_q     <= sgn & (A[N-1] ^ B[N-1]);
                  neg_r     <= sgn & A[N-1];
                  divz_pend <= (B == '0);
               end
            end
            ir_arith_pkg::RUN: begin
               dvd <= q_raw;
               rem <= step_rem;
               cnt <= cnt + 1'b1;
               if (last_step) begin
                  Q    <= q_fin;
                  R    <= r_fin;
                  DIVZ <= divz_pend;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ir_seqdiv.sv
// Directed bench for ir_seqdiv (N=8): latency, results, START-while-busy, reset abort, optional signed mode.
module tb_ir_seqdiv;

   localparam int N = 8;

   logic         CLK = 1'b0;
   logic         RESETN;
   logic         START;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         sgn;
   logic         BUSY;
   logic         DONE;
   logic [N-1:0] Q;
   logic [N-1:0] R;
   logic         DIVZ;

   int checks = 0;
   int errors = 0;
   int pulses;
   int first;

   always #5 CLK = ~CLK;

   ir_seqdiv #(.N(N)) dut (
      .CLK    (CLK),
      .RESETN (RESETN),
      .START  (START),
      .A      (A),
      .B      (B),
`ifdef IR_SEQDIV_SIGNED_EN
      .SIGNED (sgn),
`endif
      .BUSY   (BUSY),
      .DONE   (DONE),
      .Q      (Q),
      .R      (R),
      .DIVZ   (DIVZ)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a falling edge; START is held over exactly one rising edge (cycle t).
   task automatic run_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic s, input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic ez);
      int lat;
      A     = a;
      B     = b;
      sgn   = s;
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      A     = ~a;
      B     = ~b;
      sgn   = ~s;
      lat   = 1;
      check({tag, "_busy"}, 32'(BUSY), 32'd1);
      while (DONE !== 1'b1 && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'd9);
      check({tag, "_q"}, 32'(Q), 32'(eq));
      check({tag, "_r"}, 32'(R), 32'(er));
      check({tag, "_divz"}, 32'(DIVZ), 32'(ez));
      @(negedge CLK);
      check({tag, "_idle"}, {30'd0, BUSY, DONE}, 32'd0);
   endtask

   initial begin
      RESETN = 1'b0;
      START  = 1'b1;
      A      = 8'd9;
      B      = 8'd3;
      sgn    = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_q", 32'(Q), 32'd0);
      check("rst_r", 32'(R), 32'd0);
      check("rst_divz", 32'(DIVZ), 32'd0);
      RESETN = 1'b1;
      START  = 1'b0;
      @(negedge CLK);
      check("rst_start_ignored", 32'(BUSY), 32'd0);

      run_div("d100_7", 8'd100, 8'd7, 1'b0, 8'd14, 8'd2, 1'b0);
      repeat (3) @(negedge CLK);
      check("hold_q", 32'(Q), 32'd14);
      check("hold_r", 32'(R), 32'd2);

      run_div("d5_0", 8'd5, 8'd0, 1'b0, 8'hFF, 8'd5, 1'b1);
      run_div("d255_1", 8'd255, 8'd1, 1'b0, 8'd255, 8'd0, 1'b0);
      run_div("d254_16", 8'd254, 8'd16, 1'b0, 8'd15, 8'd14, 1'b0);
      run_div("d7_9", 8'd7, 8'd9, 1'b0, 8'd0, 8'd7, 1'b0);
      run_div("d255_255", 8'd255, 8'd255, 1'b0, 8'd1, 8'd0, 1'b0);
      run_div("d0_5", 8'd0, 8'd5, 1'b0, 8'd0, 8'd0, 1'b0);

      // Second START while running must not disturb the result or add a pulse.
      A      = 8'd100;
      B      = 8'd7;
      START  = 1'b1;
      pulses = 0;
      first  = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge CLK);
         if (DONE === 1'b1) begin
            pulses++;
            if (first == 0) first = c;
         end
         case (c)
            1: START = 1'b0;
            3: begin
               A     = 8'd9;
               B     = 8'd3;
               START = 1'b1;
            end
            4: START = 1'b0;
            default: begin
            end
         endcase
      end
      check("ovl_pulses", 32'(pulses), 32'd1);
      check("ovl_cycle", 32'(first), 32'd9);
      check("ovl_q", 32'(Q), 32'd14);
      check("ovl_r", 32'(R), 32'd2);

      // Reset at t+4 aborts the operation; a new START at t+6 finishes at t+15.
      A      = 8'd100;
      B      = 8'd7;
      START  = 1'b1;
      pulses = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge CLK);
         if (DONE === 1'b1) pulses++;
         if (c == 1) START = 1'b0;
         if (c == 4) RESETN = 1'b0;
         if (c == 5) begin
            check("abort_busy", 32'(BUSY), 32'd0);
            check("abort_q", 32'(Q), 32'd0);
            check("abort_r", 32'(R), 32'd0);
            RESETN = 1'b1;
         end
      end
      @(negedge CLK);
      if (DONE === 1'b1) pulses++;
      run_div("post_rst", 8'd200, 8'd13, 1'b0, 8'd15, 8'd5, 1'b0);
      check("abort_pulses", 32'(pulses), 32'd0);

`ifdef IR_SEQDIV_SIGNED_EN
      run_div("s_m7_2", 8'hF9, 8'd2, 1'b1, 8'hFD, 8'hFF, 1'b0);
      run_div("s_min_m1", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
      run_div("s_7_m2", 8'd7, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0);
      run_div("s_div0", 8'h85, 8'd0, 1'b1, 8'hFF, 8'h85, 1'b1);
      run_div("u_f9_2", 8'hF9, 8'd2, 1'b0, 8'd124, 8'd1, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
